// File: rtl/score_display_pkg.sv
// score_display_pkg: shared types and constants for the score display slice.
// Holds the conversion state type, BCD digit vector type, widths and the
// active-low seven-segment table (bit0 = segment a ... bit6 = segment g).
package score_display_pkg;

    localparam int DIGITS = 4;                // display digits
    localparam int BIN_W  = 16;               // width of the binary shift register
    localparam int SAT_W  = 14;               // width of a saturated value (max 9999)
    localparam int ITER_W = $clog2(BIN_W);    // shift counter width
    localparam int IDX_W  = $clog2(DIGITS);   // digit index width

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // One nibble per decimal digit, element 0 = ones.
    typedef logic [DIGITS-1:0][3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, entry 0 at the right-hand end.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    // Digit to segment pattern; non-decimal codes blank the digit.
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (digit <= 4'd9) begin
            pattern = SEG_TABLE[digit];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// score_display_if: result bus between the reaction-timer manager (master)
// and the score display (slave). Carries the show level, the captured time
// and the display/status outputs.
interface score_display_if;
    import score_display_pkg::*;

    logic              show;      // high = result valid, light the digits
    logic [BIN_W-1:0]  time_ms;   // elapsed time in ms, sampled on show rise
    logic [6:0]        seg_n;     // segments a..g, active-low
    logic [DIGITS-1:0] an_n;      // digit enables, bit0 = ones, active-low
    logic              busy;      // conversion in progress
    logic              valid;     // displayed BCD holds a completed conversion
    logic              overflow;  // last captured time exceeded the display range

    modport master (
        output show, time_ms,
        input  seg_n, an_n, busy, valid, overflow
    );

    modport slave (
        input  show, time_ms,
        output seg_n, an_n, busy, valid, overflow
    );

endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 (double-dabble) binary to BCD engine.
// A start pulse loads the operand and restarts from any state. The engine
// then performs BIN_W correct-and-shift steps, spends one cycle in COMMIT
// (o_done high) and returns to IDLE. o_bcd is the scratch register; it is
// only meaningful while o_done is high.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic             clk,
    input  logic             reset,     // synchronous, active-high
    input  logic             i_start,   // load i_bin and (re)start
    input  logic [BIN_W-1:0] i_bin,     // operand, must be <= 9999
    output logic             o_busy,    // high from start until COMMIT ends
    output logic             o_done,    // scratch holds a finished result
    output bcd_t             o_bcd      // BCD scratch
);

    state_t            r_state;
    state_t            w_state_next;
    logic [BIN_W-1:0]  r_bin;
    bcd_t              r_bcd;
    bcd_t              w_bcd_adj;
    logic [ITER_W-1:0] r_iter;
    logic              w_last;

    // The step taken while r_iter holds BIN_W-1 is the final shift.
    assign w_last = (r_iter == ITER_W'(BIN_W - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a start wins in every state so a new operand
    // always restarts the conversion.
    always_comb begin
        // NOTE: default assignment first, so every path drives the signal and no latch is inferred.
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = CONVERT;
        end else begin
            case (r_state)
                IDLE:    w_state_next = IDLE;
                CONVERT: if (w_last) w_state_next = COMMIT;
                COMMIT:  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Output logic: a start arriving in COMMIT suppresses that commit so
    // only the newest operand ever reaches the display.
    always_comb begin
        o_busy = (r_state != IDLE);
        o_done = (r_state == COMMIT) && !i_start;
    end

    // Add-3 correction of every BCD nibble that is 5 or more.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[i] >= 4'd5) begin
                w_bcd_adj[i] = r_bcd[i] + 4'd3;
            end
        end
    end

    // Shift datapath: load on start, correct-and-shift while converting.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the scratch registers are cleared on reset as well, so an aborted conversion leaves nothing behind.
            r_bin  <= '0;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (i_start) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_iter <= '0;
        end else if (r_state == CONVERT) begin
            // NOTE: non-blocking, so the shift sees the pre-edge {bcd, bin} as one word.
            {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
            r_iter         <= r_iter + ITER_W'(1);
        end
    end

    assign o_bcd = r_bcd;

endmodule

// File: rtl/score_display.sv
// score_display: takes the elapsed-time result from the reaction-timer
// manager, saturates it to 9999, converts it to BCD with bin2bcd_seq and
// drives a time-multiplexed, active-low 4-digit seven-segment display.
// Each digit stays lit for REFRESH_DIV clocks (REFRESH_DIV >= 2, and
// 2**CNT_W >= REFRESH_DIV).
// Build option: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zero
// digits (the ones digit is never blanked). Undefined, all four digits light.
module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,  // clocks per lit digit
    parameter int CNT_W       = 17,      // refresh counter width
    parameter int SAT_VALUE   = 9999     // largest displayable value
)(
    input  logic          clk,
    input  logic          reset,   // synchronous, active-high
    score_display_if.slave bus
);

    localparam logic [BIN_W-1:0] SAT_BIN  = BIN_W'(SAT_VALUE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    // Capture path
    logic              r_show_q;
    logic              w_rise;
    logic              w_over;
    logic [SAT_W-1:0]  w_sat;

    // Engine interface
    logic              w_busy;
    logic              w_done;
    bcd_t              w_bcd_scratch;

    // Displayed result
    bcd_t              r_bcd;
    logic              r_valid;
    logic              r_overflow;

    // Scan
    logic [CNT_W-1:0]  r_refresh_cnt;
    logic [IDX_W-1:0]  r_digit_idx;
    logic [DIGITS-1:0] w_blank_mask;
    logic [3:0]        w_digit;
    logic [DIGITS-1:0] w_an_next;
    logic [6:0]        w_seg_next;
    logic [DIGITS-1:0] r_an_n;
    logic [6:0]        r_seg_n;

    assign w_rise = bus.show & ~r_show_q;
    assign w_over = (bus.time_ms > SAT_BIN);
    assign w_sat  = w_over ? SAT_BIN[SAT_W-1:0] : bus.time_ms[SAT_W-1:0];

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .reset   (reset),
        .i_start (w_rise),
        .i_bin   ({{(BIN_W - SAT_W){1'b0}}, w_sat}),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd_scratch)
    );

    // Show edge detect, overflow capture and commit of finished conversions.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_show_q   <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_show_q <= bus.show;
            if (w_rise) begin
                r_overflow <= w_over;
            end
            if (w_done) begin
                r_bcd   <= w_bcd_scratch;
                r_valid <= 1'b1;
            end
        end
    end

    // Free-running refresh counter; the digit index steps at each wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= '0;
        end else if (r_refresh_cnt == CNT_LAST) begin
            r_refresh_cnt <= '0;
            r_digit_idx   <= r_digit_idx + IDX_W'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + CNT_W'(1);
        end
    end

    // Leading-zero mask: a slot is blank when it and every higher digit are zero.
    always_comb begin
        w_blank_mask = '0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        w_blank_mask[3] = (r_bcd[3] == 4'd0);
        w_blank_mask[2] = (r_bcd[3] == 4'd0) && (r_bcd[2] == 4'd0);
        w_blank_mask[1] = (r_bcd[3] == 4'd0) && (r_bcd[2] == 4'd0) && (r_bcd[1] == 4'd0);
`endif
    end

    assign w_digit = r_bcd[r_digit_idx];

    // Decode of the current slot: dark unless shown and holding a valid result.
    always_comb begin
        w_an_next  = '1;
        w_seg_next = SEG_BLANK;
        if (bus.show && r_valid && !w_blank_mask[r_digit_idx]) begin
            w_an_next[r_digit_idx] = 1'b0;
            w_seg_next             = seg_encode(w_digit);
        end
    end

    // Registered display outputs, one cycle behind the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_BLANK;
        end else begin
            r_an_n  <= w_an_next;
            r_seg_n <= w_seg_next;
        end
    end

    assign bus.seg_n    = r_seg_n;
    assign bus.an_n     = r_an_n;
    assign bus.busy     = w_busy;
    assign bus.valid    = r_valid;
    assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_score_display.sv
// tb_score_display: self-checking bench for score_display with REFRESH_DIV=4.
// A behavioural model (countdown to commit, arithmetic digit extraction,
// scan slot from elapsed cycles) is checked against every output each cycle;
// a constant table of conversions and hand-written sequences cover latency,
// saturation, restart, reset abort and show drop.
module tb_score_display;

    localparam int DIV = 4;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    score_display_if bus();

    score_display #(
        .REFRESH_DIV (DIV),
        .CNT_W       (3),
        .SAT_VALUE   (9999)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit         m_show_q  = 1'b0;
    int         m_left    = 0;     // edges until commit, 0 = idle
    int         m_pending = 0;
    int         m_value   = 0;
    bit         m_valid   = 1'b0;
    bit         m_ovf     = 1'b0;
    int         m_tick    = 0;     // non-reset edges since reset
    logic [3:0] m_an      = 4'hF;
    logic [6:0] m_seg     = 7'h7F;

    bit         watch_1234 = 1'b0;
    int         hits_1234  = 0;
    logic [7:0] seen [4];

    typedef struct {
        logic [15:0] tm;
        logic [15:0] bcd;
        bit          ovf;
    } vec_t;
    vec_t vecs [8];

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic bit ref_blank(input int value, input int slot);
        return LZB && (slot > 0) && (value < pow10(slot));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic model_edge(input bit s, input int t, input bit r);
        int idx;
        if (r) begin
            m_show_q = 1'b0; m_left = 0; m_pending = 0; m_value = 0;
            m_valid = 1'b0; m_ovf = 1'b0; m_tick = 0;
            m_an = 4'hF; m_seg = 7'h7F;
        end else begin
            idx   = (m_tick / DIV) % 4;
            m_an  = 4'hF;
            m_seg = 7'h7F;
            if (s && m_valid && !ref_blank(m_value, idx)) begin
                m_an[idx] = 1'b0;
                m_seg     = ref_seg((m_value / pow10(idx)) % 10);
            end
            if (s && !m_show_q) begin
                m_pending = (t > 9999) ? 9999 : t;
                m_ovf     = (t > 9999);
                m_left    = 17;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_value = m_pending;
                    m_valid = 1'b1;
                end
            end
            m_show_q = s;
            m_tick++;
        end
    endtask

    // Drive inputs, clock once, compare every output on the falling edge.
    task automatic tick(input bit s, input logic [15:0] t, input bit r);
        bus.show    = s;
        bus.time_ms = t;
        reset       = r;
        @(posedge clk);
        model_edge(s, int'(t), r);
        @(negedge clk);
        check("an_n",     32'(bus.an_n),     32'(m_an));
        check("seg_n",    32'(bus.seg_n),    32'(m_seg));
        check("busy",     32'(bus.busy),     32'(m_left > 0));
        check("valid",    32'(bus.valid),    32'(m_valid));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        if (watch_1234) begin
            for (int d = 1; d <= 4; d++) begin
                if (bus.seg_n == ref_seg(d)) hits_1234++;
            end
        end
    endtask

    // Start a conversion from show low and check the 17-cycle latency.
    task automatic convert(input logic [15:0] t);
        tick(1'b0, t, 1'b0);
        tick(1'b0, t, 1'b0);
        tick(1'b1, t, 1'b0);                       // edge k
        check("lat_busy_k", 32'(bus.busy), 32'd1);
        for (int i = 0; i < 16; i++) tick(1'b1, t, 1'b0);
        check("lat_busy_k16", 32'(bus.busy), 32'd1);
        tick(1'b1, t, 1'b0);                       // edge k+17
        check("lat_valid", 32'(bus.valid), 32'd1);
        check("lat_idle",  32'(bus.busy),  32'd0);
    endtask

    // Watch one full scan and record the pattern shown in each slot.
    task automatic scan(input logic [15:0] t);
        for (int i = 0; i < 4; i++) seen[i] = 8'hFF;
        for (int c = 0; c < 4 * DIV; c++) begin
            tick(1'b1, t, 1'b0);
            for (int i = 0; i < 4; i++) begin
                if (bus.an_n == ~(4'b0001 << i)) seen[i] = {1'b0, bus.seg_n};
            end
        end
    endtask

    task automatic check_digits(input string name, input logic [15:0] exp_bcd);
        logic [7:0] want;
        bit         blank;
        for (int i = 0; i < 4; i++) begin
            blank = LZB && (i > 0) && ((exp_bcd >> (4 * i)) == 16'd0);
            want  = blank ? 8'hFF : {1'b0, ref_seg(int'(exp_bcd[4*i +: 4]))};
            check($sformatf("%s_dig%0d", name, i), 32'(seen[i]), 32'(want));
        end
    endtask

    initial begin
        vecs[0] = '{16'd273,   16'h0273, 1'b0};
        vecs[1] = '{16'd65535, 16'h9999, 1'b1};
        vecs[2] = '{16'd0,     16'h0000, 1'b0};
        vecs[3] = '{16'd9999,  16'h9999, 1'b0};
        vecs[4] = '{16'd10000, 16'h9999, 1'b1};
        vecs[5] = '{16'd42,    16'h0042, 1'b0};
        vecs[6] = '{16'd1000,  16'h1000, 1'b0};
        vecs[7] = '{16'd8086,  16'h8086, 1'b0};

        // Reset for two cycles with show low, then idle.
        tick(1'b0, 16'd0, 1'b1);
        tick(1'b0, 16'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 16'd0, 1'b0);

        // Table of conversions.
        for (int v = 0; v < 8; v++) begin
            convert(vecs[v].tm);
            check($sformatf("vec%0d_ovf", v), 32'(bus.overflow), 32'(vecs[v].ovf));
            scan(vecs[v].tm);
            check_digits($sformatf("vec%0d", v), vecs[v].bcd);
        end

        // Restart: 1234 is replaced by 5 before it can commit.
        watch_1234 = 1'b1;
        hits_1234  = 0;
        tick(1'b0, 16'd1234, 1'b0);
        tick(1'b0, 16'd1234, 1'b0);
        tick(1'b1, 16'd1234, 1'b0);                // edge k
        for (int i = 0; i < 4; i++) tick(1'b1, 16'd1234, 1'b0);
        tick(1'b0, 16'd1234, 1'b0);                // k+5: show drops
        tick(1'b1, 16'd5, 1'b0);                   // second rise
        for (int i = 0; i < 16; i++) tick(1'b1, 16'd5, 1'b0);
        check("rs_busy", 32'(bus.busy), 32'd1);
        check("rs_valid_kept", 32'(bus.valid), 32'd1);
        tick(1'b1, 16'd5, 1'b0);
        check("rs_valid", 32'(bus.valid), 32'd1);
        check("rs_idle", 32'(bus.busy), 32'd0);
        scan(16'd5);
        check_digits("restart", 16'h0005);
        watch_1234 = 1'b0;
        check("rs_no_1234", 32'(hits_1234), 32'd0);

        // Reset at k+8 aborts the conversion; a fresh one then works.
        tick(1'b0, 16'd4321, 1'b0);
        tick(1'b0, 16'd4321, 1'b0);
        tick(1'b1, 16'd4321, 1'b0);                // edge k
        for (int i = 0; i < 7; i++) tick(1'b1, 16'd4321, 1'b0);
        tick(1'b1, 16'd4321, 1'b1);                // edge k+8 with reset
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst_an",    32'(bus.an_n),  32'hF);
        convert(16'd4321);
        scan(16'd4321);
        check_digits("after_rst", 16'h4321);

        // Show drop darkens the display; a zero result shows "0".
        tick(1'b0, 16'd0, 1'b0);
        check("drop_an",  32'(bus.an_n),  32'hF);
        check("drop_seg", 32'(bus.seg_n), 32'h7F);
        convert(16'd0);
        check("zero_ovf", 32'(bus.overflow), 32'd0);
        scan(16'd0);
        check_digits("zero", 16'h0000);

        // Randomised stimulus against the model.
        begin
            bit          s;
            bit          r;
            logic [15:0] t;
            s = 1'b0;
            for (int c = 0; c < 800; c++) begin
                if ($urandom_range(0, 7) == 0) s = ~s;
                t = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12000)) : 16'($urandom);
                r = ($urandom_range(0, 199) == 0);
                tick(s, t, r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
